axis_i2c_rx_packer: RTL and testbench
=====================================

# axis_i2c_rx_packer

Receive-side stage directly downstream of the AXI-Stream I2C master. Takes the one-cycle read-data strobes (`rvalid`, 8-bit `rdata`) that the master emits at the end of each read transaction. Packs consecutive bytes little-endian into `PACK_BYTES`-wide words and buffers them in a show-ahead FIFO. Presents the words on an AXI-Stream master port with `tkeep`/`tlast`, so a DMA or host bridge can collect I2C read results without tracking individual transactions.

## Interface
- `DATA_WIDTH`, 8: byte width; must equal the I2C master data width.
- `PACK_BYTES`, 4: bytes per output word; ≥ 1.
- `DEPTH`, 16: FIFO depth in words; power of two, ≥ 2.
- `TIMEOUT`, 1024: idle cycles before a partial word is flushed; ≥ 2.
- `clk_i`  in  1  clock, all logic on rising edge.
- `arst_i`  in  1  asynchronous, active-high reset.
- `rdata_i`  in  DATA_WIDTH  read byte from the I2C master.
- `rvalid_i`  in  1  one-cycle strobe; `rdata_i` valid. No backpressure, always accepted.
- `flush_i`  in  1  pulse; close the current partial word now.
- `clr_i`  in  1  pulse; clear `overflow_o`.
- `m_axis_tdata`  out  PACK_BYTES*DATA_WIDTH  packed word; first byte in bits [DATA_WIDTH-1:0].
- `m_axis_tkeep`  out  PACK_BYTES  bit i set when byte i is valid.
- `m_axis_tlast`  out  1  word was closed by timeout or flush.
- `m_axis_tvalid`  out  1  FIFO not empty.
- `m_axis_tready`  in  1  downstream accepts.
- `overflow_o`  out  1  sticky: a completed word was dropped.
- `level_o`  out  $clog2(DEPTH)+1  FIFO occupancy in words.

## Operation
- **Packer**
  - Holds a shift/assembly register, a byte index `idx` (0..PACK_BYTES-1) and a partial flag.
  - On `rvalid_i`, the byte is written to lane `idx` and `idx` increments.
- **Word close.** Three closing events, each pushing the assembled word into the FIFO at the same edge:
  - `rvalid_i` fills lane PACK_BYTES-1: close with `tlast`=0 and all-ones `tkeep`.
  - `flush_i`, or the timeout counter reaching TIMEOUT-1, while the partial word is non-empty: close with `tlast`=1 and `tkeep` = low `idx` bits set.
  - After any close, `idx` returns to 0 and the assembly register clears.
- **Simultaneous `rvalid_i` and flush/timeout.** The incoming byte is included in the closed word, then `tlast`=1.
  - If that byte fills the word, `tkeep` is all ones and `tlast`=1.
- **Flush with no partial bytes.** Flush or timeout with no pending bytes is a no-op: no zero-`tkeep` word is ever produced.
- **Timeout counter**
  - Clears on `rvalid_i` and on every close.
  - Increments each cycle while partial bytes are held.
  - Holds at 0 while no partial bytes are held.
- **FIFO**
  - DEPTH entries of {tdata, tkeep, tlast}; read pointer wraps modulo DEPTH.
  - Show-ahead: `m_axis_tvalid` = !empty; outputs reflect the head entry.
  - Pop on `tvalid && tready`.
- **Full FIFO.** `full` is evaluated before any same-cycle pop. A push while full drops the word and sets `overflow_o`; the packer still resets, and the FIFO contents are untouched.
- **`overflow_o`** stays set until a `clr_i` pulse. If `clr_i` and a new overflow occur in the same cycle, set wins.
- **Reset mid-operation** discards the partial word and all FIFO contents immediately (asynchronous).

## Timing
- **Reset values:** `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tkeep`=0, `m_axis_tlast`=0, `overflow_o`=0, `level_o`=0. `idx`, pointers and timeout counter are 0.
- **Latency**
  - A closing event sampled at edge N gives `m_axis_tvalid`=1 in the cycle after edge N when the FIFO was empty.
  - `level_o` updates at the same edge.
- **Timeout flush.** The last `rvalid_i` at edge N with no further input gives a flush push at edge N+TIMEOUT.
- **AXI-Stream stability.** Once `m_axis_tvalid` is high, `tdata`/`tkeep`/`tlast` stay stable until the handshake; `tvalid` never drops without a handshake.
- **Throughput**
  - One push and one pop per cycle when not full.
  - Simultaneous push and pop leaves `level_o` unchanged.
  - Back-to-back `rvalid_i` on every cycle is legal.

## Test plan
- **Full words.** PACK_BYTES=4; bytes 0x11,0x22,0x33,0x44 on four strobes, `tready`=1 -> one beat with tdata=0x44332211, tkeep=0xF, tlast=0, one cycle after the 4th strobe.
- **Timeout flush.** Bytes 0xA5,0x5A then idle, TIMEOUT=16 -> beat tdata=0x00005AA5, tkeep=0x3, tlast=1, pushed exactly 16 edges after the 2nd strobe. A `flush_i` pulse on an empty packer produces no beat.
- **Simultaneous events.** `flush_i` in the same cycle as the 4th byte 0x44 -> single beat with tkeep=0xF, tlast=1, then no extra beat.
- **Overflow.** DEPTH=4, `tready`=0, push 5 full words -> `level_o`=4, `overflow_o`=1. Then `tready`=1 drains the first 4 words in order. `clr_i` clears `overflow_o`.
- **Backpressure.** Toggle `tready` randomly for 64 words -> every output word is stable while stalled, with no loss or reorder against a scoreboard. `level_o` wraps correctly through pointer wrap-around.
- **Reset mid-operation.** Assert `arst_i` with 2 partial bytes held and 3 words buffered -> `m_axis_tvalid`=0 and `level_o`=0 immediately. The next 4 bytes form a clean word with tkeep=0xF.

Source files
------------

// File: rtl/axis_i2c_rx_packer.sv
// axis_i2c_rx_packer
//
// Collects the one-cycle read-byte strobes of an I2C master, packs them
// little-endian into PACK_BYTES-wide words and queues the words in a
// show-ahead FIFO that drives an AXI-Stream master port.
//
// Ports:
//   clk_i, arst_i           clock, asynchronous active-high reset
//   rdata_i, rvalid_i       read byte and its one-cycle strobe (never stalled)
//   flush_i                 close the current partial word now
//   clr_i                   clear the sticky overflow flag
//   m_axis_t*               packed word stream (tkeep marks valid bytes,
//                           tlast marks a word closed by flush or timeout)
//   overflow_o              sticky: a completed word was dropped (FIFO full)
//   level_o                 FIFO occupancy in words
module axis_i2c_rx_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_BYTES = 4,
  parameter int DEPTH      = 16,
  parameter int TIMEOUT    = 1024
) (
  input  logic                            clk_i,
  input  logic                            arst_i,
  input  logic [DATA_WIDTH-1:0]           rdata_i,
  input  logic                            rvalid_i,
  input  logic                            flush_i,
  input  logic                            clr_i,
  output logic [PACK_BYTES*DATA_WIDTH-1:0] m_axis_tdata,
  output logic [PACK_BYTES-1:0]           m_axis_tkeep,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            overflow_o,
  output logic [$clog2(DEPTH):0]          level_o
);

  localparam int WW = PACK_BYTES * DATA_WIDTH;
  localparam int IW = (PACK_BYTES > 1) ? $clog2(PACK_BYTES) : 1;
  localparam int CW = IW + 1;
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam int EW = WW + PACK_BYTES + 1;

  logic [IW-1:0]         idx_q, idx_d;
  logic [WW-1:0]         asm_q, asm_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [PW-1:0]         wr_q, wr_d;
  logic [PW-1:0]         rd_q, rd_d;
  logic                  ovf_q, ovf_d;
  logic [EW-1:0]         mem_q [DEPTH];

  logic [WW-1:0]         asm_fill;
  logic [CW-1:0]         byte_cnt;
  logic [PACK_BYTES-1:0] keep_d;
  logic [EW-1:0]         entry_d;
  logic                  partial;
  logic                  fill;
  logic                  timeout_hit;
  logic                  soft_close;
  logic                  close;
  logic [PW-1:0]         level;
  logic                  empty;
  logic                  full;
  logic                  push;
  logic                  pop;

  // Packer: assemble bytes, decide when a word closes and what it carries.
  always_comb begin
    asm_fill = asm_q;
    if (rvalid_i) begin
      asm_fill[idx_q*DATA_WIDTH +: DATA_WIDTH] = rdata_i;
    end

    // A full word is pushed the moment its last lane fills, so idx != 0
    // is exactly "partial bytes are held".
    partial     = (idx_q != '0);
    fill        = rvalid_i && (idx_q == IW'(PACK_BYTES - 1));
    timeout_hit = partial && (tmo_q == TW'(TIMEOUT - 1));
    // A same-cycle byte counts as content, so flush + first byte still closes.
    soft_close  = (flush_i || timeout_hit) && (partial || rvalid_i);
    close       = fill || soft_close;

    // Bytes in the closing word include a same-cycle strobe; a filled word
    // yields PACK_BYTES and hence all-ones keep.
    byte_cnt = {1'b0, idx_q} + CW'(rvalid_i);
    keep_d   = '0;
    for (int i = 0; i < PACK_BYTES; i++) begin
      keep_d[i] = (CW'(i) < byte_cnt);
    end
    entry_d = {soft_close, keep_d, asm_fill};

    idx_d = idx_q;
    asm_d = asm_q;
    tmo_d = '0;
    if (close) begin
      idx_d = '0;
      asm_d = '0;
    end else if (rvalid_i) begin
      idx_d = idx_q + IW'(1);
      asm_d = asm_fill;
    end else if (partial) begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  // FIFO control: full is judged on the current state, before any pop.
  always_comb begin
    level = wr_q - rd_q;
    empty = (wr_q == rd_q);
    full  = (level == PW'(DEPTH));
    push  = close && !full;
    pop   = !empty && m_axis_tready;
    wr_d  = wr_q + PW'(push);
    rd_d  = rd_q + PW'(pop);

    ovf_d = ovf_q;
    if (close && full) begin
      ovf_d = 1'b1;
    end else if (clr_i) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      idx_q <= '0;
      asm_q <= '0;
      tmo_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      asm_q <= asm_d;
      tmo_q <= tmo_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      ovf_q <= ovf_d;
    end
  end

  // Storage is not reset; the outputs are masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_q[AW-1:0]] <= entry_d;
    end
  end

  assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} =
    empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign m_axis_tvalid = !empty;
  assign overflow_o    = ovf_q;
  assign level_o       = level;

endmodule

// File: tb/tb_axis_i2c_rx_packer.sv
// Bench for axis_i2c_rx_packer (PACK_BYTES=4, DEPTH=4, TIMEOUT=16).
// Expected beats are queued by the stimulus; a negedge monitor pops and
// compares them on each handshake and checks beat stability while stalled.
module tb_axis_i2c_rx_packer;
  localparam int DW    = 8;
  localparam int PB    = 4;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic        clk = 1'b0;
  logic        arst;
  logic [7:0]  rdata;
  logic        rvalid, flush, clr, tready;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast, tvalid, ovf;
  logic [2:0]  level;

  int checks = 0;
  int passes = 0;
  logic [36:0] sb[$];
  logic        rand_rdy = 1'b0;
  logic        stalled  = 1'b0;
  logic [36:0] held     = '0;

  always #5 clk = ~clk;

  axis_i2c_rx_packer #(
    .DATA_WIDTH(DW), .PACK_BYTES(PB), .DEPTH(DEPTH), .TIMEOUT(TMO)
  ) dut (
    .clk_i(clk), .arst_i(arst), .rdata_i(rdata), .rvalid_i(rvalid),
    .flush_i(flush), .clr_i(clr),
    .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tlast(tlast),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .overflow_o(ovf), .level_o(level)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: scoreboard compare on handshake, stability while stalled.
  always @(negedge clk) begin
    if (arst) begin
      stalled <= 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", 64'(tvalid), 64'd1);
        check("stall_beat", 64'({tlast, tkeep, tdata}), 64'(held));
      end
      if (tvalid && tready) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_beat: got 0x%0h, expected no beat", {tlast, tkeep, tdata});
        end else begin
          check("beat", 64'({tlast, tkeep, tdata}), 64'(sb.pop_front()));
        end
      end
      stalled <= tvalid && !tready;
      held    <= {tlast, tkeep, tdata};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) tready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [7:0] b, input logic fl = 1'b0);
    rvalid = 1'b1;
    rdata  = b;
    flush  = fl;
    tick();
    rvalid = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit expect_push);
    if (expect_push) sb.push_back({1'b0, 4'hF, w});
    for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || tvalid) && n < budget) begin
      tick();
      n++;
    end
    check("drain_in_time", 64'(n < budget), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    arst = 1'b1; rvalid = 1'b0; rdata = '0; flush = 1'b0; clr = 1'b0; tready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_tvalid", 64'(tvalid), 64'd0);
    check("rst_tdata", 64'(tdata), 64'd0);
    check("rst_tkeep", 64'(tkeep), 64'd0);
    check("rst_tlast", 64'(tlast), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    @(posedge clk); #1;
    arst = 1'b0;
    tick();

    // Full word
    tready = 1'b1;
    sb.push_back({1'b0, 4'hF, 32'h44332211});
    send(8'h11); send(8'h22); send(8'h33);
    @(negedge clk);
    check("full_no_early", 64'(tvalid), 64'd0);
    send(8'h44);
    @(negedge clk);
    check("full_latency", 64'(tvalid), 64'd1);
    check("full_level", 64'(level), 64'd1);
    tick();
    wait_drain(10);

    // Timeout flush: push exactly TMO edges after the last strobe
    sb.push_back({1'b1, 4'h3, 32'h00005AA5});
    send(8'hA5); send(8'h5A);
    repeat (TMO - 1) tick();
    @(negedge clk);
    check("tmo_not_early", 64'(tvalid), 64'd0);
    tick();
    @(negedge clk);
    check("tmo_push", 64'(tvalid), 64'd1);
    check("tmo_level", 64'(level), 64'd1);
    tick();
    wait_drain(10);

    // Flush on empty packer is a no-op
    flush = 1'b1; tick(); flush = 1'b0;
    repeat (TMO + 4) tick();
    check("empty_flush_level", 64'(level), 64'd0);
    check("empty_flush_sb", 64'(sb.size()), 64'd0);

    // Flush together with the filling byte
    sb.push_back({1'b1, 4'hF, 32'h44332211});
    send(8'h11); send(8'h22); send(8'h33); send(8'h44, 1'b1);
    repeat (TMO + 4) tick();
    check("simul_fill_sb", 64'(sb.size()), 64'd0);
    check("simul_fill_level", 64'(level), 64'd0);

    // Flush with a byte that does not fill, then flush alone
    sb.push_back({1'b1, 4'h3, 32'h00008877});
    send(8'h77); send(8'h88, 1'b1);
    sb.push_back({1'b1, 4'h1, 32'h00000099});
    send(8'h99);
    flush = 1'b1; tick(); flush = 1'b0;
    repeat (TMO + 4) tick();
    check("partial_flush_sb", 64'(sb.size()), 64'd0);

    // Overflow: five words into a four-deep FIFO
    tready = 1'b0;
    for (int w = 0; w < 5; w++) send_word(32'h10203040 + 32'h01010101 * w, w < 4);
    @(negedge clk);
    check("ovf_level", 64'(level), 64'd4);
    check("ovf_flag", 64'(ovf), 64'd1);
    tick();
    tready = 1'b1;
    wait_drain(20);
    check("ovf_sticky", 64'(ovf), 64'd1);
    clr = 1'b1; tick(); clr = 1'b0;
    @(negedge clk);
    check("ovf_clr", 64'(ovf), 64'd0);
    tick();

    // Backpressure with random tready
    rand_rdy = 1'b1;
    for (int w = 0; w < 64; w++) begin
      int n = 0;
      while (level >= 3'(DEPTH) && n < 200) begin
        tick();
        n++;
      end
      send_word($urandom, 1'b1);
    end
    rand_rdy = 1'b0;
    tready   = 1'b1;
    wait_drain(100);
    check("bp_level", 64'(level), 64'd0);
    check("bp_ovf", 64'(ovf), 64'd0);

    // Reset mid-operation
    tready = 1'b0;
    for (int w = 0; w < 3; w++) send_word(32'hC0C1C2C3 + 32'(w), 1'b1);
    send(8'hEE); send(8'hEF);
    @(negedge clk);
    check("pre_rst_level", 64'(level), 64'd3);
    tick();
    arst = 1'b1;
    #1;
    check("mid_rst_tvalid", 64'(tvalid), 64'd0);
    check("mid_rst_level", 64'(level), 64'd0);
    sb.delete();
    tick(); tick();
    arst   = 1'b0;
    tready = 1'b1;
    tick();
    send_word(32'hDDCCBBAA, 1'b1);
    wait_drain(10);
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
